// File: rtl/univ_counter_ctrl.sv
// rtl/univ_counter_ctrl.sv - sequencing controller for a universal binary counter
module univ_counter_ctrl #(
    parameter int N      = 8,
    parameter int DIV_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic              mode_reload,
    input  logic              dir_up,
    input  logic [N-1:0]      limit,
    input  logic [DIV_W-1:0]  div,
    input  logic [N-1:0]      cnt_q,
    input  logic              cnt_min_tick,
    output logic              cnt_syn_clr,
    output logic              cnt_load,
    output logic              cnt_en,
    output logic              cnt_up,
    output logic [N-1:0]      cnt_d,
    output logic              busy,
    output logic              done_tick,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       limit_r, limit_nxt;
    logic               dir_r, dir_nxt;
    logic               mode_r, mode_nxt;
    logic [DIV_W-1:0]   div_r, div_nxt;
    logic [DIV_W-1:0]   presc, presc_nxt;
    logic [WRAP_W-1:0]  wrap_r, wrap_nxt;
    logic               term;

    // Terminal test looks at the counter as it stands, before any step this cycle.
    assign term     = dir_r ? (cnt_q == limit_r) : cnt_min_tick;
    assign wrap_cnt = wrap_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            limit_r <= '0;
            dir_r   <= 1'b0;
            mode_r  <= 1'b0;
            div_r   <= '0;
            presc   <= '0;
            wrap_r  <= '0;
        end else begin
            state   <= state_nxt;
            limit_r <= limit_nxt;
            dir_r   <= dir_nxt;
            mode_r  <= mode_nxt;
            div_r   <= div_nxt;
            presc   <= presc_nxt;
            wrap_r  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        limit_nxt   = limit_r;
        dir_nxt     = dir_r;
        mode_nxt    = mode_r;
        div_nxt     = div_r;
        presc_nxt   = presc;
        wrap_nxt    = wrap_r;
        cnt_syn_clr = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_up      = 1'b0;
        cnt_d       = '0;
        busy        = 1'b0;
        done_tick   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    limit_nxt = limit;
                    dir_nxt   = dir_up;
                    mode_nxt  = mode_reload;
                    div_nxt   = div;
                    wrap_nxt  = '0;
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                busy   = 1'b1;
                cnt_up = dir_r;
                if (dir_r) begin
                    cnt_syn_clr = 1'b1;
                end else begin
                    cnt_load = 1'b1;
                    cnt_d    = limit_r;
                end
                presc_nxt = '0;
                state_nxt = stop ? S_IDLE : S_RUN;
            end

            S_RUN: begin
                busy   = 1'b1;
                cnt_up = dir_r;
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (term) begin
                    // Never enable at terminal: the counter must not wrap past limit.
                    done_tick = 1'b1;
                    wrap_nxt  = wrap_r + 1'b1;
                    state_nxt = mode_r ? S_LOAD : S_IDLE;
                end else if (!hold) begin
                    if (presc == div_r) begin
                        cnt_en    = 1'b1;
                        presc_nxt = '0;
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_univ_counter_ctrl.sv
// tb/tb_univ_counter_ctrl.sv - self-checking bench for univ_counter_ctrl
module tb_univ_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, hold, mode_reload, dir_up;
    logic [7:0] limit;
    logic [3:0] div;
    logic [7:0] cnt_q;
    logic       cnt_min_tick;
    logic       cnt_syn_clr, cnt_load, cnt_en, cnt_up, busy, done_tick;
    logic [7:0] cnt_d, wrap_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    bit checking = 0;
    bit rec      = 0;
    int q_done[$], q_en[$], q_clr[$], q_load[$];

    // Abstract model: phase 0 idle, 1 load, 2 run; steps = counter steps taken.
    int m_phase = 0, m_lim = 0, m_dir = 0, m_mode = 0, m_div = 0;
    int m_wrap = 0, m_steps = 0, m_ticks = 0;

    univ_counter_ctrl #(.N(8), .DIV_W(4), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
        .mode_reload(mode_reload), .dir_up(dir_up), .limit(limit), .div(div),
        .cnt_q(cnt_q), .cnt_min_tick(cnt_min_tick),
        .cnt_syn_clr(cnt_syn_clr), .cnt_load(cnt_load), .cnt_en(cnt_en),
        .cnt_up(cnt_up), .cnt_d(cnt_d), .busy(busy), .done_tick(done_tick),
        .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    // The controlled universal counter.
    always @(posedge clk) begin
        if (reset)            cnt_q <= 8'd0;
        else if (cnt_syn_clr) cnt_q <= 8'd0;
        else if (cnt_load)    cnt_q <= cnt_d;
        else if (cnt_en)      cnt_q <= cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
    end
    assign cnt_min_tick = (cnt_q == 8'd0);

    function automatic bit m_term();
        return m_phase == 2 && m_steps == m_lim;
    endfunction

    function automatic bit m_en();
        return m_phase == 2 && !stop && !m_term() && !hold &&
               ((m_ticks % (m_div + 1)) == m_div);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_phase = 0; m_wrap = 0; m_lim = 0; m_dir = 0; m_mode = 0; m_div = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_lim = limit; m_dir = dir_up; m_mode = mode_reload; m_div = div;
                    m_wrap = 0; m_phase = 1;
                end
                1: if (stop) m_phase = 0;
                   else begin m_phase = 2; m_steps = 0; m_ticks = 0; end
                default: begin
                    if (stop) m_phase = 0;
                    else if (m_term()) begin
                        m_wrap = (m_wrap + 1) % 256;
                        m_phase = m_mode ? 1 : 0;
                    end else if (!hold) begin
                        if (m_en()) m_steps++;
                        m_ticks++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [20:0] ev, av;
        logic [7:0]  ed, ew, eq;
        if (checking) begin
            ed = (m_phase == 1 && !m_dir) ? 8'(m_lim) : 8'd0;
            ew = 8'(m_wrap);
            ev = {m_phase == 1 && m_dir == 1, m_phase == 1 && m_dir == 0, m_en(),
                  m_phase != 0 && m_dir == 1, ed, m_phase != 0,
                  m_phase == 2 && !stop && m_term(), ew};
            av = {cnt_syn_clr, cnt_load, cnt_en, cnt_up, cnt_d, busy, done_tick, wrap_cnt};
            total++;
            if (av !== ev) begin
                bad++;
                $display("FAIL outputs cyc=%0d: got %h expected %h", cyc, av, ev);
            end
            if (m_phase == 2) begin
                eq = m_dir ? 8'(m_steps) : 8'(m_lim - m_steps);
                total++;
                if (cnt_q !== eq) begin
                    bad++;
                    $display("FAIL cnt_q cyc=%0d: got %0d expected %0d", cyc, cnt_q, eq);
                end
            end
        end
        if (rec) begin
            if (done_tick)   q_done.push_back(cyc - t0);
            if (cnt_en)      q_en.push_back(cyc - t0);
            if (cnt_syn_clr) q_clr.push_back(cyc - t0);
            if (cnt_load)    q_load.push_back(cyc - t0);
        end
    end

    task automatic run_scn(input int lim, input int dv, input int dir, input int mode,
                           input int ncyc, input int hf, input int ht, input int stop_at,
                           input int rst_at, input int start2_at, input int lim2);
        q_done.delete(); q_en.delete(); q_clr.delete(); q_load.delete();
        t0 = cyc;
        rec = 1;
        limit = 8'(lim); div = 4'(dv); dir_up = dir[0]; mode_reload = mode[0];
        for (int rel = 0; rel < ncyc; rel++) begin
            start = (rel == 0) || (rel == start2_at);
            if (rel == start2_at) limit = 8'(lim2);
            hold  = (rel >= hf) && (rel <= ht);
            stop  = (rel == stop_at);
            reset = (rel == rst_at);
            @(posedge clk);
            #1;
        end
        start = 0; hold = 0; stop = 0; reset = 0;
        rec = 0;
    endtask

    initial begin
        reset = 1; start = 0; stop = 0; hold = 0; mode_reload = 0; dir_up = 0;
        limit = 0; div = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        checking = 1;
        chk("reset_busy", busy, 0);
        chk("reset_wrap", wrap_cnt, 0);

        // one-shot up
        run_scn(5, 0, 1, 0, 10, -1, -1, -1, -1, -1, 0);
        chk("s1_done_n", q_done.size(), 1);
        chk("s1_done_at", q_done.size() > 0 ? q_done[0] : -1, 7);
        chk("s1_clr_at", q_clr.size() > 0 ? q_clr[0] : -1, 1);
        chk("s1_en_n", q_en.size(), 5);
        chk("s1_en_first", q_en.size() > 0 ? q_en[0] : -1, 2);
        chk("s1_en_last", q_en.size() > 4 ? q_en[4] : -1, 6);
        chk("s1_wrap", wrap_cnt, 1);
        chk("s1_q", cnt_q, 5);

        // one-shot down, prescaled
        run_scn(3, 2, 0, 0, 14, -1, -1, -1, -1, -1, 0);
        chk("s2_load_at", q_load.size() > 0 ? q_load[0] : -1, 1);
        chk("s2_en_n", q_en.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("s2_en_at", q_en.size() > i ? q_en[i] : -1, 4 + 3 * i);
        chk("s2_done_at", q_done.size() > 0 ? q_done[0] : -1, 11);
        chk("s2_q", cnt_q, 0);

        // auto-reload, then stop
        run_scn(2, 0, 1, 1, 20, -1, -1, 13, -1, -1, 0);
        chk("s3_done_n", q_done.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("s3_done_at", q_done.size() > i ? q_done[i] : -1, 4 + 4 * i);
            chk("s3_clr_at", q_clr.size() > i ? q_clr[i] : -1, 1 + 4 * i);
        end
        chk("s3_wrap", wrap_cnt, 3);
        chk("s3_busy", busy, 0);

        // edge limits
        run_scn(0, 0, 1, 0, 5, -1, -1, -1, -1, -1, 0);
        chk("s4_up0_done", q_done.size() > 0 ? q_done[0] : -1, 2);
        chk("s4_up0_en", q_en.size(), 0);
        run_scn(0, 0, 0, 0, 5, -1, -1, -1, -1, -1, 0);
        chk("s4_dn0_done", q_done.size() > 0 ? q_done[0] : -1, 2);
        chk("s4_dn0_en", q_en.size(), 0);
        run_scn(255, 0, 1, 0, 260, -1, -1, -1, -1, -1, 0);
        chk("s4_max_done", q_done.size() > 0 ? q_done[0] : -1, 257);
        chk("s4_max_q", cnt_q, 255);

        // hold plus ignored start with a new limit
        run_scn(5, 0, 1, 0, 14, 3, 5, -1, -1, 4, 9);
        chk("s5_done_n", q_done.size(), 1);
        chk("s5_done_at", q_done.size() > 0 ? q_done[0] : -1, 10);
        chk("s5_q", cnt_q, 5);

        // reset mid-run, then a normal run
        run_scn(3, 2, 0, 0, 8, -1, -1, -1, 4, -1, 0);
        chk("s6_rst_done_n", q_done.size(), 0);
        chk("s6_rst_busy", busy, 0);
        run_scn(5, 0, 1, 0, 10, -1, -1, -1, -1, -1, 0);
        chk("s6_after_done", q_done.size() > 0 ? q_done[0] : -1, 7);

        // stop coinciding with term
        run_scn(2, 0, 1, 1, 8, -1, -1, 4, -1, -1, 0);
        chk("s6_stopterm_done_n", q_done.size(), 0);
        chk("s6_stopterm_wrap", wrap_cnt, 0);

        // reset clears a nonzero wrap count
        run_scn(2, 0, 1, 1, 8, -1, -1, -1, 5, -1, 0);
        chk("s6_rst_wrap_done_n", q_done.size(), 1);
        chk("s6_rst_wrap", wrap_cnt, 0);

        // wrap_cnt rolls over 255 -> 0
        run_scn(0, 0, 1, 1, 518, -1, -1, 515, -1, -1, 0);
        chk("s7_done_n", q_done.size(), 257);
        chk("s7_wrap", wrap_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_counter_ctrl.md
Name: univ_counter_ctrl

Overview:
- Sequencing controller for the universal binary counter: drives its syn_clr/load/en/up/d inputs and watches its q/min_tick outputs.
- Runs one-shot or auto-reload count intervals, up from 0 to a limit or down from a limit to 0.
- Includes a programmable prescaler (enable strobe every div+1 cycles) plus hold and stop control.
- Sits between a register/control front-end and one counter instance; both are clocked by the same clk and reset by the same reset.

Parameters:
- N, 8, counter width; must match the controlled counter.
- DIV_W, 4, prescaler divisor width.
- WRAP_W, 8, width of the reload-interval counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  reset, synchronous and active-high.
- start  in  1  start request; sampled in IDLE only.
- stop  in  1  abort request; effective in LOAD/RUN.
- hold  in  1  freezes prescaler and counting while in RUN.
- mode_reload  in  1  0 = one-shot, 1 = auto-reload.
- dir_up  in  1  1 = count up 0→limit, 0 = count down limit→0.
- limit  in  N  terminal/load value.
- div  in  DIV_W  prescale divisor; counter steps once per div+1 RUN cycles.
- cnt_q  in  N  counter q.
- cnt_min_tick  in  1  counter min_tick.
- cnt_syn_clr  out  1  to counter syn_clr.
- cnt_load  out  1  to counter load.
- cnt_en  out  1  to counter en.
- cnt_up  out  1  to counter up.
- cnt_d  out  N  to counter d.
- busy  out  1  high in LOAD and RUN.
- done_tick  out  1  one-cycle pulse at interval completion.
- wrap_cnt  out  WRAP_W  completed intervals since the last start.

Behaviour:
- **Reset:** synchronous. At the next edge: state = IDLE; limit_r, dir_r, mode_r, div_r, prescaler and wrap_cnt = 0. All outputs are 0 while in IDLE. Reset overrides everything, including in mid-RUN.
- **Output decode:** counter control outputs are combinational from state and registers; the counter reacts on the following edge.
- **IDLE:**
  - start=1 latches limit→limit_r, dir_up→dir_r, mode_reload→mode_r, div→div_r, clears wrap_cnt, and moves to LOAD.
  - start=0: remain in IDLE.
- **LOAD (exactly 1 cycle):**
  - dir_r=1: cnt_syn_clr=1.
  - dir_r=0: cnt_load=1, cnt_d=limit_r.
  - cnt_en=0. Prescaler cleared to 0. Next state RUN.
  - stop=1: go to IDLE instead.
- **RUN:**
  - term = dir_r ? (cnt_q==limit_r) : cnt_min_tick. term is evaluated before any step.
  - Priority: stop > term > hold > count.
  - stop=1 → IDLE. No done_tick, no enable, counter keeps its value.
  - term=1 → done_tick=1 and cnt_en=0 this cycle. If mode_r=1: wrap_cnt+1 (mod 2^WRAP_W) and go to LOAD. If mode_r=0: wrap_cnt+1 and go to IDLE.
  - hold=1 → prescaler and cnt_en frozen at 0.
  - Otherwise, when prescaler==div_r: cnt_en=1, cnt_up=dir_r, prescaler←0. Else prescaler+1.
- **Latency:** start at cycle s → LOAD at s+1 → first RUN cycle at s+2 → done_tick at s+2+limit_r·(div_r+1), with no hold.
- **Reload period:** limit_r·(div_r+1)+2 cycles.
- **Boundary conditions:**
  - limit_r=0: term is true in the first RUN cycle, so done_tick fires at s+2 in either direction.
  - limit=2^N−1 up: counter reaches its max and stops. The counter never wraps because the controller never enables it at terminal.
  - start while busy is ignored. limit/dir/mode/div changes while busy take effect only at the next start.
  - wrap_cnt wraps from 2^WRAP_W−1 to 0.
  - cnt_up=dir_r in LOAD/RUN, 0 in IDLE.

Test Plan:
1. **One-shot up.** N=8, limit=5, div=0, dir_up=1, mode=0, start at cycle 0 → cnt_syn_clr=1 at cycle 1; cnt_en=1 cycles 2–6; done_tick at cycle 7 with cnt_q=5; busy=0 from cycle 8; wrap_cnt=1.
2. **One-shot down with prescale.** limit=3, div=2, dir_up=0, start at 0 → cnt_load=1 with cnt_d=3 at cycle 1; cnt_en at cycles 4, 7, 10; done_tick at cycle 11 with cnt_q=0.
3. **Auto-reload.** limit=2, div=0, up, mode=1 → done_tick at cycles 4, 8, 12; wrap_cnt=1,2,3; cnt_syn_clr at cycles 1, 5, 9. Then stop at cycle 13 → IDLE at 14, no further done_tick.
4. **Edge values.** limit=0 (up and down) → done_tick at cycle 2, no cnt_en ever. limit=255, div=0, up → done_tick at cycle 257 with cnt_q=255.
5. **Hold and ignored start.** Scenario 1 with hold=1 during cycles 3–5 → done_tick moves to cycle 10. Pulse start again at cycle 4 with limit=9 → ignored, still terminates at 5.
6. **Reset and stop mid-run.** reset=1 at cycle 4 of scenario 2 → at cycle 5 state IDLE, busy=0, all counter controls 0, wrap_cnt=0. A new start then runs normally. stop asserted together with term → no done_tick.
